// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared cache-side definitions: line/beat geometry, data typedefs and the
// adapter FSM state encoding used by the datacache, arbiter and adapter.
package cacheline_burst_adapter_pkg;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BEAT_WIDTH  = 64;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_t;

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Line-side and burst-side signals of the adapter; slave is the adapter view,
// master is the view of the surrounding cache controller and memory arbiter.
interface cacheline_burst_adapter_if
  import cacheline_burst_adapter_pkg::*;
#(
  parameter int unsigned LW = LINE_WIDTH,
  parameter int unsigned BW = BEAT_WIDTH,
  parameter int unsigned AW = ADDR_WIDTH
);
  logic          line_read;
  logic          line_write;
  logic [AW-1:0] line_addr;
  logic [LW-1:0] line_wdata;
  logic [LW-1:0] line_rdata;
  logic          line_resp;

  logic          burst_read;
  logic          burst_write;
  logic [AW-1:0] burst_addr;
  logic [BW-1:0] burst_wdata;
  logic [BW-1:0] burst_rdata;
  logic          burst_resp;

  modport slave (
    input  line_read, line_write, line_addr, line_wdata, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_read, burst_write, burst_addr, burst_wdata
  );

  modport master (
    output line_read, line_write, line_addr, line_wdata, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_read, burst_write, burst_addr, burst_wdata
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts 256-bit cache line reads/writes into ascending 4 x 64-bit memory
// bursts and reassembles read beats into a line. All outputs are registered.
module cacheline_burst_adapter
  import cacheline_burst_adapter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = cacheline_burst_adapter_pkg::LINE_WIDTH,
  parameter int unsigned BEAT_WIDTH = cacheline_burst_adapter_pkg::BEAT_WIDTH,
  parameter int unsigned ADDR_WIDTH = cacheline_burst_adapter_pkg::ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cacheline_burst_adapter_if.slave bus
);

  localparam int unsigned NBEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W  = $clog2(NBEATS);
  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [LINE_WIDTH-1:0]   buffer;

  logic [CNT_W-1:0]        cnt_inc;
  logic                    last_beat;
  logic [LINE_WIDTH-1:0]   fill_next;
  logic [BEAT_WIDTH-1:0]   wbeat_next;
  logic [ADDR_WIDTH-1:0]   aligned_addr;

  // fill_next is the buffer with the incoming read beat merged in, so the
  // final beat can go straight to line_rdata on the same edge.
  always_comb begin
    cnt_inc      = beat_cnt + 1'b1;
    last_beat    = (beat_cnt == CNT_W'(NBEATS - 1));
    fill_next    = buffer;
    fill_next[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] = bus.burst_rdata;
    wbeat_next   = buffer[cnt_inc*BEAT_WIDTH +: BEAT_WIDTH];
    aligned_addr = {bus.line_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      buffer          <= '0;
      bus.line_rdata  <= '0;
      bus.line_resp   <= 1'b0;
      bus.burst_read  <= 1'b0;
      bus.burst_write <= 1'b0;
      bus.burst_addr  <= '0;
      bus.burst_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.line_write) begin
            bus.burst_addr  <= aligned_addr;
            buffer          <= bus.line_wdata;
            bus.burst_wdata <= bus.line_wdata[BEAT_WIDTH-1:0];
            beat_cnt        <= '0;
            bus.burst_write <= 1'b1;
            state           <= WR_BURST;
          end else if (bus.line_read) begin
            bus.burst_addr  <= aligned_addr;
            beat_cnt        <= '0;
            bus.burst_read  <= 1'b1;
            state           <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (bus.burst_resp) begin
            buffer   <= fill_next;
            beat_cnt <= cnt_inc;
            if (last_beat) begin
              bus.burst_read <= 1'b0;
              bus.line_rdata <= fill_next;
              bus.line_resp  <= 1'b1;
              state          <= RD_DONE;
            end
          end
        end

        WR_BURST: begin
          if (bus.burst_resp) begin
            beat_cnt        <= cnt_inc;
            bus.burst_wdata <= wbeat_next;
            if (last_beat) begin
              bus.burst_write <= 1'b0;
              bus.line_resp   <= 1'b1;
              state           <= WR_DONE;
            end
          end
        end

        RD_DONE, WR_DONE: begin
          bus.line_resp <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Directed bench for cacheline_burst_adapter: a vector table of line
// transactions against a beat-level memory responder, plus reset/spurious cases.
module tb_cacheline_burst_adapter;
  import cacheline_burst_adapter_pkg::*;

  logic clk;
  logic rst_n;

  cacheline_burst_adapter_if bus ();

  cacheline_burst_adapter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    addr_t       addr;
    line_t       wdata;
    line_t       beats;     // read beat k is beats[64k +: 64]
    logic [15:0] mask;      // bit c: offer burst_resp in cycle c after the request
    logic        spur_done; // also pulse burst_resp while line_resp is high
    addr_t       exp_addr;
    line_t       exp_line;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   k;
    int   nresp;
    int   last_c;
    int   resp_c;
    logic act_req;
    logic oth_req;
    k      = 0;
    nresp  = 0;
    last_c = -10;
    resp_c = 0;
    bus.line_read  = v.rd;
    bus.line_write = v.wr;
    bus.line_addr  = v.addr;
    bus.line_wdata = v.wdata;
    bus.burst_resp = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      bus.burst_resp  = 1'b0;
      bus.burst_rdata = 64'(cyc) ^ 64'hDEAD_0000_0000_0000;
      act_req = v.exp_wr ? bus.burst_write : bus.burst_read;
      oth_req = v.exp_wr ? bus.burst_read  : bus.burst_write;
      check({name, " other_req_low"}, 256'(oth_req), 256'd0);
      if (nresp == 0 && k < 4) begin
        check({name, " req_high"}, 256'(act_req), 256'd1);
        check({name, " burst_addr"}, 256'(bus.burst_addr), 256'(v.exp_addr));
      end
      if (k == 4 && cyc == last_c + 1)
        check({name, " req_drop"}, 256'(act_req), 256'd0);
      if (bus.line_resp) begin
        nresp++;
        if (nresp == 1) begin
          resp_c = cyc;
          check({name, " resp_latency"}, 256'(cyc), 256'(last_c + 1));
          if (!v.exp_wr)
            check({name, " line_rdata"}, bus.line_rdata, v.exp_line);
          bus.line_read  = 1'b0;
          bus.line_write = 1'b0;
          if (v.spur_done) bus.burst_resp = 1'b1;
        end
      end
      if (nresp == 0 && k < 4 && cyc < 16 && v.mask[cyc]) begin
        if (v.exp_wr)
          check({name, " burst_wdata"}, 256'(bus.burst_wdata), 256'(v.wdata[64*k +: 64]));
        else
          bus.burst_rdata = v.beats[64*k +: 64];
        bus.burst_resp = 1'b1;
        k++;
        last_c = cyc;
      end
      if (nresp == 0) begin
        bus.line_addr  = $urandom();
        bus.line_wdata = {8{$urandom()}};
      end
      if (nresp > 0 && cyc >= resp_c + 3) break;
    end
    bus.burst_resp = 1'b0;
    check({name, " resp_count"}, 256'(nresp), 256'd1);
    check({name, " beats_taken"}, 256'(k), 256'd4);
    if (!v.exp_wr)
      check({name, " rdata_hold"}, bus.line_rdata, v.exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hv;

    vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, wdata: '0,
                beats: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                mask: 16'h001E, spur_done: 1'b1, exp_addr: 32'h0000_1220,
                exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                exp_wr: 1'b0};
    vecs[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_ABCD,
                wdata: 256'hFEDCBA9876543210_DEADBEEFCAFEF00D_5555AAAA5555AAAA_0123456789ABCDEF,
                beats: '0, mask: 16'h0264, spur_done: 1'b0, exp_addr: 32'h0000_ABC0,
                exp_line: '0, exp_wr: 1'b1};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'hFFFF_FFFF,
                wdata: 256'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A_0F0F0F0F0F0F0F0F_F0F0F0F0F0F0F0F0,
                beats: '0, mask: 16'h001E, spur_done: 1'b0, exp_addr: 32'hFFFF_FFE0,
                exp_line: '0, exp_wr: 1'b1};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'h8000_001F,
                beats: 256'hCAFEBABE00000003_0BADF00D00000002_1357924680000001_FFFFFFFFFFFFFFFF,
                wdata: '0, mask: 16'h009A, spur_done: 1'b0, exp_addr: 32'h8000_0000,
                exp_line: 256'hCAFEBABE00000003_0BADF00D00000002_1357924680000001_FFFFFFFFFFFFFFFF,
                exp_wr: 1'b0};

    rst_n = 1'b0;
    bus.line_read   = 1'b0;
    bus.line_write  = 1'b0;
    bus.line_addr   = '0;
    bus.line_wdata  = '0;
    bus.burst_rdata = '0;
    bus.burst_resp  = 1'b0;
    #23;
    check("rst line_resp",   256'(bus.line_resp),   256'd0);
    check("rst line_rdata",  bus.line_rdata,        256'd0);
    check("rst burst_read",  256'(bus.burst_read),  256'd0);
    check("rst burst_write", 256'(bus.burst_write), 256'd0);
    check("rst burst_addr",  256'(bus.burst_addr),  256'd0);
    check("rst burst_wdata", 256'(bus.burst_wdata), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Spurious responses while idle must not move the beat counter.
    for (int i = 0; i < 3; i++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); #1;
      check("idle_spur burst_read",  256'(bus.burst_read),  256'd0);
      check("idle_spur burst_write", 256'(bus.burst_write), 256'd0);
      check("idle_spur line_resp",   256'(bus.line_resp),   256'd0);
    end
    bus.burst_resp = 1'b0;
    hv = vecs[3];
    hv.addr     = 32'h0000_0040;
    hv.exp_addr = 32'h0000_0040;
    hv.mask     = 16'h001E;
    run_vec(hv, "after_idle_spur");

    // Reset in the middle of a read after two beats.
    bus.line_read = 1'b1;
    bus.line_addr = 32'h2000_0044;
    @(posedge clk); #1;
    check("mid_rst req_high", 256'(bus.burst_read), 256'd1);
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'h1111_0000_0000_0000;
    @(posedge clk); #1;
    bus.burst_rdata = 64'h2222_0000_0000_0000;
    @(posedge clk); #1;
    bus.burst_resp = 1'b0;
    check("mid_rst still_busy", 256'(bus.burst_read), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst async_drop", 256'(bus.burst_read), 256'd0);
    check("mid_rst line_resp",  256'(bus.line_resp),  256'd0);
    check("mid_rst burst_addr", 256'(bus.burst_addr), 256'd0);
    bus.line_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    hv = vecs[0];
    hv.addr      = 32'h2000_0044;
    hv.exp_addr  = 32'h2000_0040;
    hv.spur_done = 1'b0;
    hv.mask      = 16'h0056;
    run_vec(hv, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
